// File: rtl/parking_day_ctrl_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types and constants for the parking day controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    typedef enum logic [0:0] {
        S_DAY  = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 3;
    localparam int HOUR_W    = 4;
    localparam int ADDR_W    = 3;

    localparam logic [NUM_SLOTS-1:0] FULL_MASK = 3'b111;

    function automatic logic [1:0] popcount3(input logic [NUM_SLOTS-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/parking_day_ctrl_scan_timer.sv
// ============================================================================
// Module   : scan_timer
// Purpose  : Free-running divider producing one step pulse every SCAN_DIV
//            enabled cycles; used to pace the end-of-day readout address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_timer #(
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int              c_CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CW-1:0] c_TERM = c_CW'(SCAN_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_term;

    assign w_term = (r_cnt == c_TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

    assign step = en & ~clr & w_term;

endmodule

`default_nettype wire

// File: rtl/parking_day_ctrl.sv
// ============================================================================
// Module   : parking_day_ctrl
// Purpose  : Work-day hour sequencer with per-hour car-count RAM, rush-hour
//            detection and end-of-day RAM readout sweep.
// Options  : PARK_EDGE_COUNT_EN - count cars from rising slot-occupancy bits
//            instead of the car_enter pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_day_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_HOURS = 8,
    parameter int SCAN_DIV  = 50_000_000,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] parking_status,
    input  logic                 car_enter,
    input  logic                 hour_tick,
    input  logic                 new_day,
    output logic [HOUR_W-1:0]    work_hour,
    output logic                 work_day_expired,
    output logic [HOUR_W-1:0]    rush_start,
    output logic                 rush_start_exist,
    output logic [HOUR_W-1:0]    rush_end,
    output logic                 rush_end_exist,
    output logic [ADDR_W-1:0]    car_track_ram_addr,
    output logic [CNT_W-1:0]     car_track_ram_out
);

    localparam logic [HOUR_W-1:0] c_LAST_HOUR = HOUR_W'(NUM_HOURS - 1);
    localparam logic [ADDR_W-1:0] c_TOP_ADDR  = ADDR_W'(NUM_HOURS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOUR_W-1:0]   r_work_hour;
    logic [HOUR_W-1:0]   r_rush_start;
    logic [HOUR_W-1:0]   r_rush_end;
    logic                r_rs_exist;
    logic                r_re_exist;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_ram_out;
    logic [CNT_W-1:0]    r_ram [NUM_HOURS];

    logic                w_day;
    logic                w_last_hour;
    logic                w_enter_scan;
    logic                w_new_day;
    logic                w_step;
    logic [1:0]          w_inc;
    logic [ADDR_W-1:0]   w_idx;
    logic [CNT_W:0]      w_sum;

    assign w_day        = (r_state == S_DAY);
    assign w_last_hour  = (r_work_hour == c_LAST_HOUR);
    assign w_enter_scan = w_day & hour_tick & w_last_hour;
    assign w_new_day    = (r_state == S_SCAN) & new_day;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_DAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_DAY:   if (hour_tick && w_last_hour) w_state_nxt = S_SCAN;
            S_SCAN:  if (new_day) w_state_nxt = S_DAY;
            default: w_state_nxt = S_DAY;
        endcase
    end

`ifdef PARK_EDGE_COUNT_EN
    logic [NUM_SLOTS-1:0] r_prev;
    logic                 w_unused_car;

    assign w_unused_car = car_enter;

    // Reload on new_day so slots already occupied at day start are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else if (w_day || w_new_day) begin
            r_prev <= parking_status;
        end
    end

    assign w_inc = w_day ? popcount3(parking_status & ~r_prev) : 2'd0;
`else
    assign w_inc = {1'b0, w_day & car_enter};
`endif

    assign w_idx = r_work_hour[ADDR_W-1:0];
    assign w_sum = {1'b0, r_ram[w_idx]} + {{(CNT_W-1){1'b0}}, w_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HOURS; i++) r_ram[i] <= '0;
        end else if (w_new_day) begin
            for (int i = 0; i < NUM_HOURS; i++) r_ram[i] <= '0;
        end else if (w_inc != 2'd0) begin
            r_ram[w_idx] <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work_hour  <= '0;
            r_rush_start <= '0;
            r_rush_end   <= '0;
            r_rs_exist   <= 1'b0;
            r_re_exist   <= 1'b0;
        end else if (w_new_day) begin
            r_work_hour  <= '0;
            r_rush_start <= '0;
            r_rush_end   <= '0;
            r_rs_exist   <= 1'b0;
            r_re_exist   <= 1'b0;
        end else if (w_day) begin
            if (hour_tick && !w_last_hour) r_work_hour <= r_work_hour + 1'b1;
            // End qualifies on the registered start flag, so both never latch together.
            if (parking_status == FULL_MASK && !r_rs_exist) begin
                r_rush_start <= r_work_hour;
                r_rs_exist   <= 1'b1;
            end else if (parking_status == '0 && r_rs_exist && !r_re_exist) begin
                r_rush_end   <= r_work_hour;
                r_re_exist   <= 1'b1;
            end
        end
    end

    scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_state == S_SCAN),
        .clr   (w_enter_scan | w_new_day),
        .step  (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= c_TOP_ADDR;
        end else if (w_enter_scan || w_new_day) begin
            r_addr <= c_TOP_ADDR;
        end else if (w_step) begin
            r_addr <= (r_addr == '0) ? c_TOP_ADDR : r_addr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_out <= '0;
        end else begin
            r_ram_out <= r_ram[r_addr];
        end
    end

    assign work_hour          = r_work_hour;
    assign work_day_expired   = (r_state == S_SCAN);
    assign rush_start         = r_rush_start;
    assign rush_start_exist   = r_rs_exist;
    assign rush_end           = r_rush_end;
    assign rush_end_exist     = r_re_exist;
    assign car_track_ram_addr = r_addr;
    assign car_track_ram_out  = r_ram_out;

endmodule

`default_nettype wire

// File: tb/tb_parking_day_ctrl.sv
// ============================================================================
// Module   : tb_parking_day_ctrl
// Purpose  : Directed self-checking bench for parking_day_ctrl (SCAN_DIV=4).
//            Honours PARK_EDGE_COUNT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_day_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  parking_status = 3'b000;
    logic        car_enter = 1'b0;
    logic        hour_tick = 1'b0;
    logic        new_day = 1'b0;
    logic [3:0]  work_hour;
    logic        work_day_expired;
    logic [3:0]  rush_start;
    logic        rush_start_exist;
    logic [3:0]  rush_end;
    logic        rush_end_exist;
    logic [2:0]  car_track_ram_addr;
    logic [15:0] car_track_ram_out;

    int errors = 0;
    int checks = 0;

    logic [15:0] e_ram [8];

    parking_day_ctrl #(
        .NUM_HOURS (8),
        .SCAN_DIV  (4),
        .CNT_W     (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .parking_status     (parking_status),
        .car_enter          (car_enter),
        .hour_tick          (hour_tick),
        .new_day            (new_day),
        .work_hour          (work_hour),
        .work_day_expired   (work_day_expired),
        .rush_start         (rush_start),
        .rush_start_exist   (rush_start_exist),
        .rush_end           (rush_end),
        .rush_end_exist     (rush_end_exist),
        .car_track_ram_addr (car_track_ram_addr),
        .car_track_ram_out  (car_track_ram_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one clock's worth of inputs at the falling edge, return at the next falling edge.
    task automatic cyc(input logic ce, input logic ht, input logic nd, input logic [2:0] st);
        parking_status = st;
        car_enter      = ce;
        hour_tick      = ht;
        new_day        = nd;
        @(negedge clk);
        car_enter = 1'b0;
        hour_tick = 1'b0;
        new_day   = 1'b0;
    endtask

    // Entered at the first falling edge after the S_DAY->S_SCAN transition edge.
    task automatic scan_check(input logic [15:0] exp [8]);
        logic [2:0] a;
        logic [2:0] pa;
        for (int k = 0; k < 9; k++) begin
            a  = 3'(7 - k);
            pa = 3'(8 - k);
            for (int j = 0; j < 4; j++) begin
                if (j == 0) chk($sformatf("scan_addr k%0d", k), car_track_ram_addr, a);
                if (j == 0 && k > 0) chk($sformatf("scan_lag k%0d", k), car_track_ram_out, exp[pa]);
                if (j == 1) chk($sformatf("scan_out k%0d", k), car_track_ram_out, exp[a]);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_hour", work_hour, 0);
        chk("rst_expired", work_day_expired, 0);
        chk("rst_rs", {rush_start_exist, rush_start}, 0);
        chk("rst_re", {rush_end_exist, rush_end}, 0);
        chk("rst_addr", car_track_ram_addr, 7);
        chk("rst_out", car_track_ram_out, 0);

`ifdef PARK_EDGE_COUNT_EN
        cyc(1, 0, 0, 3'b000);
        cyc(1, 0, 0, 3'b011);
        cyc(1, 0, 0, 3'b111);
        cyc(1, 0, 0, 3'b111);
        for (int h = 0; h < 7; h++) cyc(0, 1, 0, 3'b111);
        chk("edge_hour7", work_hour, 7);
        cyc(0, 1, 0, 3'b111);
        chk("edge_expired", work_day_expired, 1);
        for (int i = 0; i < 8; i++) e_ram[i] = 16'd0;
        e_ram[0] = 16'd3;
        scan_check(e_ram);
`else
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 3'b011);
        cyc(0, 1, 0, 3'b011);
        chk("hour1", work_hour, 1);
        cyc(1, 0, 0, 3'b011);
        cyc(1, 0, 0, 3'b011);
        cyc(0, 0, 0, 3'b000);
        chk("empty_first_re", rush_end_exist, 0);
        chk("empty_first_rs", rush_start_exist, 0);
        cyc(0, 1, 0, 3'b011);
        cyc(0, 0, 0, 3'b111);
        chk("rush_start2", {rush_start_exist, rush_start}, {1'b1, 4'd2});
        for (int h = 0; h < 3; h++) cyc(0, 1, 0, 3'b011);
        cyc(0, 0, 0, 3'b000);
        chk("rush_end5", {rush_end_exist, rush_end}, {1'b1, 4'd5});
        cyc(0, 1, 0, 3'b011);
        cyc(0, 0, 0, 3'b111);
        chk("late_full_rs", rush_start, 2);
        chk("late_full_re", rush_end, 5);
        cyc(0, 1, 0, 3'b011);
        chk("hour7", work_hour, 7);
        cyc(1, 0, 0, 3'b011);
        cyc(1, 1, 0, 3'b011);
        chk("expired", work_day_expired, 1);
        chk("hour_hold", work_hour, 7);
        for (int i = 0; i < 8; i++) e_ram[i] = 16'd0;
        e_ram[0] = 16'd3;
        e_ram[1] = 16'd2;
        e_ram[7] = 16'd2;
        scan_check(e_ram);

        cyc(1, 1, 0, 3'b000);
        chk("scan_frozen_hour", work_hour, 7);
        chk("scan_frozen_re", rush_end, 5);
        chk("scan_still_expired", work_day_expired, 1);

        cyc(0, 0, 1, 3'b011);
        chk("nd_hour", work_hour, 0);
        chk("nd_expired", work_day_expired, 0);
        chk("nd_exist", {rush_start_exist, rush_end_exist}, 0);
        chk("nd_addr", car_track_ram_addr, 7);

        cyc(0, 1, 0, 3'b011);
        cyc(0, 0, 1, 3'b011);
        chk("nd_in_day_ignored", work_hour, 1);
        cyc(0, 1, 0, 3'b011);
        cyc(0, 1, 0, 3'b011);
        cyc(0, 0, 0, 3'b111);
        cyc(0, 0, 0, 3'b000);
        chk("same_hour_rs", {rush_start_exist, rush_start}, {1'b1, 4'd3});
        chk("same_hour_re", {rush_end_exist, rush_end}, {1'b1, 4'd3});
        for (int h = 0; h < 4; h++) cyc(0, 1, 0, 3'b011);
        cyc(0, 1, 0, 3'b011);
        chk("day2_expired", work_day_expired, 1);
        for (int i = 0; i < 8; i++) e_ram[i] = 16'd0;
        scan_check(e_ram);
`endif

        #2 rst_n = 1'b0;
        #1;
        chk("async_hour", work_hour, 0);
        chk("async_expired", work_day_expired, 0);
        chk("async_exist", {rush_start_exist, rush_end_exist}, 0);
        chk("async_addr", car_track_ram_addr, 7);
        chk("async_out", car_track_ram_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
